// File: rtl/instr_fetch.sv
// instr_fetch: owns the program counter, fetches one word at a time from
// instruction memory (req/gnt/rvalid handshake, one request outstanding at
// most) and buffers the returned words in a small FIFO that feeds decode
// over valid/ready. A redirect flushes the buffer and restarts at a new PC.
module instr_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // DROP: a request is in flight whose response must be thrown away
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_req_pc;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [31:0]         r_instr_mem [DEPTH];
  logic [ADDR_W-1:0]   r_pc_mem    [DEPTH];

  logic w_grant;
  logic w_push;
  logic w_pop;

  // A redirect kills both the pending push (stale data) and any pop
  assign w_grant     = imem_req && imem_gnt;
  assign w_push      = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop       = instr_valid && instr_ready && !redirect_valid;
  assign instr_valid = (r_count != '0);
  assign instr_out   = r_instr_mem[r_rd_ptr];
  assign instr_pc    = r_pc_mem[r_rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a redirect turns an in-flight request into a dropped one
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: if (w_grant) w_state_next = redirect_valid ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)         w_state_next = S_FETCH;
        else if (redirect_valid) w_state_next = S_DROP;
      end
      S_DROP:  if (imem_rvalid) w_state_next = S_FETCH;
      default: w_state_next = S_FETCH;
    endcase
  end

  // Request outputs; space is reserved by only requesting when the FIFO has room
  always_comb begin
    imem_req  = (r_state == S_FETCH) && (r_count < CNT_W'(DEPTH));
    imem_addr = r_pc;
  end

  // PC and in-flight request address; redirect wins over the +4 advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      if (redirect_valid) r_pc <= redirect_pc;
      else if (w_grant)   r_pc <= r_pc + ADDR_W'(4);
      if (w_grant)        r_req_pc <= r_pc;
    end
  end

  // FIFO occupancy and pointers; redirect flushes everything
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // FIFO storage, one register pair per entry, cleared on reset
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the returned word and its address into the write slot
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_instr_mem[gi] <= '0;
          r_pc_mem[gi]    <= '0;
        end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_instr_mem[gi] <= imem_rdata;
          r_pc_mem[gi]    <= r_req_pc;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table drives the memory,
// redirect and decoder inputs and checks the state-derived outputs, followed by
// a short hand sequence on a second instance with RESET_PC near the top of memory.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        rst_n, imem_gnt, imem_rvalid, redirect_valid, instr_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr_out, instr_pc;

  // Wrap instance (RESET_PC = 0xFFFFFFFC)
  logic        w_rst_n, w_gnt, w_rvalid, w_redir, w_ready;
  logic [31:0] w_rdata, w_rpc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_out, w_pc;

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redir), .redirect_pc(w_rpc),
    .instr_valid(w_valid), .instr_out(w_out), .instr_pc(w_pc),
    .instr_ready(w_ready)
  );

  typedef struct {
    logic        rst_n, gnt, rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_out, e_pc;
    logic        chk_dat;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] ADD  = 32'h0000_0000;
  localparam logic [31:0] SUB  = 32'h0400_0000;
  localparam logic [31:0] LOAD = 32'h0800_0000;
  localparam logic [31:0] JUMP = 32'h3C00_0000;

  function automatic void add(logic rs, logic g, logic rv, logic [31:0] rd,
                              logic rr, logic [31:0] rp, logic rdy,
                              logic er, logic [31:0] ea, logic ev,
                              logic [31:0] eo, logic [31:0] ep, logic force_dat);
    vec_t v;
    v.rst_n = rs; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.redir = rr; v.rpc = rp; v.rdy = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev;
    v.e_out = eo; v.e_pc = ep; v.chk_dat = ev | force_dat;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Each row is one cycle: inputs applied at the negedge, outputs checked
    // 1ns later (they depend only on registered state).
    //   rst g rv rdata   redir rpc        rdy | req addr       valid out        pc         force
    add(0, 0, 0, 0,        0, 0,          0,    1, 32'h0,      0, 32'h0,      32'h0,     1); // in reset
    // Back-to-back fetch of ADD/SUB/LOAD with 1-cycle memory
    add(1, 1, 0, 0,        0, 0,          1,    1, 32'h0,      0, 0, 0, 0);
    add(1, 0, 1, ADD,      0, 0,          1,    0, 0,          0, 0, 0, 0);
    add(1, 1, 0, 0,        0, 0,          1,    1, 32'h4,      1, ADD,        32'h0,     0);
    add(1, 0, 1, SUB,      0, 0,          1,    0, 0,          0, 0, 0, 0);
    add(1, 1, 0, 0,        0, 0,          1,    1, 32'h8,      1, SUB,        32'h4,     0);
    add(1, 0, 1, LOAD,     0, 0,          1,    0, 0,          0, 0, 0, 0);
    add(1, 0, 0, 0,        0, 0,          1,    1, 32'hC,      1, LOAD,       32'h8,     0);
    // Backpressure: FIFO fills to 2, request stops, one pop reopens it
    add(1, 1, 0, 0,        0, 0,          0,    1, 32'hC,      0, 0, 0, 0);
    add(1, 0, 1, 32'h11111111, 0, 0,      0,    0, 0,          0, 0, 0, 0);
    add(1, 1, 0, 0,        0, 0,          0,    1, 32'h10,     1, 32'h11111111, 32'hC,   0);
    add(1, 0, 1, 32'h22222222, 0, 0,      0,    0, 0,          1, 32'h11111111, 32'hC,   0);
    add(1, 1, 0, 0,        0, 0,          0,    0, 0,          1, 32'h11111111, 32'hC,   0);
    add(1, 1, 0, 0,        0, 0,          0,    0, 0,          1, 32'h11111111, 32'hC,   0);
    add(1, 1, 0, 0,        0, 0,          1,    0, 0,          1, 32'h11111111, 32'hC,   0);
    add(1, 0, 0, 0,        0, 0,          0,    1, 32'h14,     1, 32'h22222222, 32'h10,  0);
    add(1, 1, 0, 0,        0, 0,          0,    1, 32'h14,     1, 32'h22222222, 32'h10,  0);
    add(1, 0, 1, 32'h33333333, 0, 0,      1,    0, 0,          1, 32'h22222222, 32'h10,  0); // push+pop
    add(1, 0, 0, 0,        0, 0,          1,    1, 32'h18,     1, 32'h33333333, 32'h14,  0);
    // Redirect while waiting: stale JUMP dropped, restart at 0x100
    add(1, 1, 0, 0,        0, 0,          1,    1, 32'h18,     0, 0, 0, 0);
    add(1, 0, 0, 0,        1, 32'h100,    1,    0, 0,          0, 0, 0, 0);
    add(1, 0, 1, JUMP,     0, 0,          1,    0, 0,          0, 0, 0, 0);
    add(1, 1, 0, 0,        0, 0,          1,    1, 32'h100,    0, 0, 0, 0);
    add(1, 0, 1, 32'h0C000000, 0, 0,      1,    0, 0,          0, 0, 0, 0);
    add(1, 0, 0, 0,        0, 0,          0,    1, 32'h104,    1, 32'h0C000000, 32'h100, 0);
    // Redirect with grant in FETCH (and a pop that must be ignored)
    add(1, 1, 0, 0,        1, 32'h200,    1,    1, 32'h104,    1, 32'h0C000000, 32'h100, 0);
    add(1, 0, 0, 0,        0, 0,          1,    0, 0,          0, 0, 0, 0);
    add(1, 0, 1, JUMP,     0, 0,          1,    0, 0,          0, 0, 0, 0);
    add(1, 0, 0, 0,        0, 0,          1,    1, 32'h200,    0, 0, 0, 0);
    // Redirect coincident with rvalid in WAIT
    add(1, 1, 0, 0,        0, 0,          1,    1, 32'h200,    0, 0, 0, 0);
    add(1, 0, 1, JUMP,     1, 32'h300,    1,    0, 0,          0, 0, 0, 0);
    add(1, 1, 0, 0,        0, 0,          1,    1, 32'h300,    0, 0, 0, 0);
    // Redirects while in DROP only move the PC
    add(1, 0, 0, 0,        1, 32'h400,    1,    0, 0,          0, 0, 0, 0);
    add(1, 0, 0, 0,        1, 32'h500,    1,    0, 0,          0, 0, 0, 0);
    add(1, 0, 1, JUMP,     0, 0,          1,    0, 0,          0, 0, 0, 0);
    add(1, 1, 0, 0,        0, 0,          1,    1, 32'h500,    0, 0, 0, 0);
    add(1, 0, 1, 32'h44444444, 0, 0,      0,    0, 0,          0, 0, 0, 0);
    // Redirect in FETCH without grant flushes a buffered entry
    add(1, 0, 0, 0,        1, 32'h600,    0,    1, 32'h504,    1, 32'h44444444, 32'h500, 0);
    add(1, 1, 0, 0,        0, 0,          0,    1, 32'h600,    0, 0, 0, 0);
    // Reset with one entry buffered and a fetch in flight
    add(1, 0, 1, 32'h55555555, 0, 0,      0,    0, 0,          0, 0, 0, 0);
    add(1, 1, 0, 0,        0, 0,          0,    1, 32'h604,    1, 32'h55555555, 32'h600, 0);
    add(0, 0, 0, 0,        0, 0,          0,    0, 0,          1, 32'h55555555, 32'h600, 0);
    add(1, 0, 0, 0,        0, 0,          0,    1, 32'h0,      0, 32'h0,      32'h0,     1);
    add(1, 1, 0, 0,        0, 0,          0,    1, 32'h0,      0, 0, 0, 0);
    add(1, 0, 1, 32'h66666666, 0, 0,      1,    0, 0,          0, 0, 0, 0);
    add(1, 0, 0, 0,        0, 0,          1,    1, 32'h4,      1, 32'h66666666, 32'h0,   0);

    // Idle inputs, both instances held in reset for one edge
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    w_rst_n = 1'b0; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
    w_redir = 1'b0; w_rpc = '0; w_ready = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n          = vecs[i].rst_n;
      imem_gnt       = vecs[i].gnt;
      imem_rvalid    = vecs[i].rv;
      imem_rdata     = vecs[i].rdata;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      instr_ready    = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req)
        chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].chk_dat) begin
        chk($sformatf("v%0d instr_out", i), instr_out, vecs[i].e_out);
        chk($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].e_pc);
      end
      $display("[TB] v%0d req=%0b addr=%h valid=%0b out=%h pc=%h",
               i, imem_req, imem_addr, instr_valid, instr_out, instr_pc);
    end

    // PC wrap: 0xFFFFFFFC then 0x00000000
    @(negedge clk);
    w_rst_n = 1'b1; w_gnt = 1'b1; w_ready = 1'b1;
    #1;
    chk("wrap req0", {31'b0, w_req}, 32'd1);
    chk("wrap addr0", w_addr, 32'hFFFF_FFFC);
    chk("wrap valid0", {31'b0, w_valid}, 32'd0);
    @(negedge clk);
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = LOAD;
    #1;
    chk("wrap req1", {31'b0, w_req}, 32'd0);
    @(negedge clk);
    w_rvalid = 1'b0; w_gnt = 1'b1;
    #1;
    chk("wrap req2", {31'b0, w_req}, 32'd1);
    chk("wrap addr2", w_addr, 32'h0000_0000);
    chk("wrap valid2", {31'b0, w_valid}, 32'd1);
    chk("wrap out2", w_out, LOAD);
    chk("wrap pc2", w_pc, 32'hFFFF_FFFC);
    $display("[TB] wrap req=%0b addr=%h valid=%0b out=%h pc=%h",
             w_req, w_addr, w_valid, w_out, w_pc);
    @(negedge clk);
    w_gnt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
